// File: rtl/sys_ctrl_pkg.sv
// rtl/sys_ctrl_pkg.sv - shared frame codes, ALU function codes and sequencer state encoding
package sys_ctrl_pkg;

  localparam logic [7:0] CMD_ALU  = 8'hCC;
  localparam logic [7:0] ERR_CODE = 8'hEE;

  // ALU function codes 4'h0..FUN_LAST are executable; FUN_RESERVED is rejected.
  localparam logic [3:0] FUN_LAST     = 4'hE;
  localparam logic [3:0] FUN_RESERVED = 4'hF;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_GET_A    = 4'd1,
    S_GET_B    = 4'd2,
    S_GET_FUN  = 4'd3,
    S_EXEC     = 4'd4,
    S_WAIT_RES = 4'd5,
    S_TX_LO    = 4'd6,
    S_TX_HI    = 4'd7,
    S_TX_ERR   = 4'd8
  } seq_state_e;

  function automatic logic fun_byte_ok(input logic [7:0] b);
    return (b[7:4] == 4'h0) && (b[3:0] != FUN_RESERVED);
  endfunction

  // States in which an incoming byte has nowhere to go.
  function automatic logic rx_drops_byte(input seq_state_e s);
    return (s == S_EXEC) || (s == S_WAIT_RES) || (s == S_TX_LO) ||
           (s == S_TX_HI) || (s == S_TX_ERR);
  endfunction

endpackage

// File: rtl/seq_timeout_cnt.sv
// rtl/seq_timeout_cnt.sv - ALU result timeout counter with terminal-count flag
module seq_timeout_cnt #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic count_en,
  output logic term
);

  localparam int CW = $clog2(TIMEOUT);

  logic [CW-1:0] cnt;

  // Holds at terminal count so a late count_en can never wrap back to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (count_en && !term) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign term = (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - parses CMD/A/B/FUN frames, runs the ALU, returns result bytes
module alu_cmd_sequencer
  import sys_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic [15:0] alu_out,
  input  logic        alu_out_valid,
  input  logic        tx_ready,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [3:0]  alu_fun,
  output logic        alu_en,
  output logic        alu_clk_en,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  output logic        busy,
  output logic        err_overrun,
  output logic        err_timeout
);

  seq_state_e  state;
  logic [15:0] res;
  logic        tmo_term;

  seq_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (state == S_EXEC),
    .count_en (state == S_WAIT_RES),
    .term     (tmo_term)
  );

  // Outputs are updated on the transition into each state so they are
  // registered and line up exactly with the state they belong to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      res         <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_fun     <= '0;
      alu_en      <= 1'b0;
      alu_clk_en  <= 1'b0;
      tx_data     <= '0;
      tx_valid    <= 1'b0;
      busy        <= 1'b0;
      err_overrun <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      alu_en      <= 1'b0;
      err_timeout <= 1'b0;
      err_overrun <= rx_valid && rx_drops_byte(state);

      case (state)
        S_IDLE: begin
          if (rx_valid && (rx_data == CMD_ALU)) begin
            state <= S_GET_A;
            busy  <= 1'b1;
          end
        end
        S_GET_A: begin
          if (rx_valid) begin
            alu_a <= rx_data;
            state <= S_GET_B;
          end
        end
        S_GET_B: begin
          if (rx_valid) begin
            alu_b <= rx_data;
            state <= S_GET_FUN;
          end
        end
        S_GET_FUN: begin
          if (rx_valid) begin
            alu_fun <= rx_data[3:0];
            if (fun_byte_ok(rx_data)) begin
              state      <= S_EXEC;
              alu_en     <= 1'b1;
              alu_clk_en <= 1'b1;
            end else begin
              state    <= S_TX_ERR;
              tx_data  <= ERR_CODE;
              tx_valid <= 1'b1;
            end
          end
        end
        S_EXEC: begin
          state <= S_WAIT_RES;
        end
        S_WAIT_RES: begin
          // A result arriving on the terminal-count cycle still counts as success.
          if (alu_out_valid) begin
            res        <= alu_out;
            tx_data    <= alu_out[7:0];
            tx_valid   <= 1'b1;
            alu_clk_en <= 1'b0;
            state      <= S_TX_LO;
          end else if (tmo_term) begin
            err_timeout <= 1'b1;
            tx_data     <= ERR_CODE;
            tx_valid    <= 1'b1;
            alu_clk_en  <= 1'b0;
            state       <= S_TX_ERR;
          end
        end
        S_TX_LO: begin
          if (tx_ready) begin
            tx_data <= res[15:8];
            state   <= S_TX_HI;
          end
        end
        S_TX_HI, S_TX_ERR: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            busy     <= 1'b0;
            state    <= S_IDLE;
          end
        end
        default: begin
          state      <= S_IDLE;
          tx_valid   <= 1'b0;
          alu_clk_en <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb/tb_alu_cmd_sequencer.sv - scoreboard bench for alu_cmd_sequencer with random frames
module tb_alu_cmd_sequencer;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [15:0] alu_out;
  logic        alu_out_valid;
  logic        tx_ready;
  logic [7:0]  alu_a, alu_b, tx_data;
  logic [3:0]  alu_fun;
  logic        alu_en, alu_clk_en, tx_valid, busy, err_overrun, err_timeout;

  alu_cmd_sequencer #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .alu_out(alu_out), .alu_out_valid(alu_out_valid), .tx_ready(tx_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_fun(alu_fun), .alu_en(alu_en),
    .alu_clk_en(alu_clk_en), .tx_data(tx_data), .tx_valid(tx_valid), .busy(busy),
    .err_overrun(err_overrun), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic [7:0]  exp_tx[$];
  logic [19:0] exp_ops[$];
  int          exp_clk_len[$];
  int exp_timeouts = 0, got_timeouts = 0;
  int exp_overruns = 0, got_overruns = 0;
  int alu_lat = 1;
  bit stall = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                          input logic [3:0] f);
    case (f)
      4'h0: return 16'(a) + 16'(b);
      4'h1: return 16'(a) - 16'(b);
      4'h2: return 16'(a) * 16'(b);
      4'h3: return 16'(a | b);
      4'h4: return 16'(a & b);
      4'h5: return 16'(a ^ b);
      default: return {a, b} ^ {12'h0, f};
    endcase
  endfunction

  // ALU model: result valid alu_lat cycles after alu_en, never if alu_lat == 0.
  initial begin : alu_model
    logic [15:0] r;
    alu_out = '0;
    alu_out_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (alu_en && rst_n && alu_lat > 0) begin
        r = alu_ref(alu_a, alu_b, alu_fun);
        repeat (alu_lat) @(negedge clk);
        alu_out = r;
        alu_out_valid = 1'b1;
        @(negedge clk);
        alu_out_valid = 1'b0;
        alu_out = 16'($urandom);
      end
    end
  end

  initial begin : ready_drv
    tx_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      tx_ready = stall ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  int clk_run = 0;
  bit hold_pending = 1'b0;
  logic [7:0] held_data;

  always @(negedge clk) begin
    if (!rst_n) begin
      clk_run = 0;
      hold_pending = 1'b0;
    end else begin
      if (alu_en) begin
        if (exp_ops.size() == 0) begin
          total++; bad++;
          $display("FAIL alu_en_unexpected actual=1 required=0");
        end else begin
          check("alu_operands", {alu_a, alu_b, alu_fun}, exp_ops.pop_front());
        end
      end
      if (alu_clk_en) begin
        clk_run++;
      end else if (clk_run > 0) begin
        if (exp_clk_len.size() == 0) begin
          total++; bad++;
          $display("FAIL alu_clk_en_unexpected actual=%0d required=0", clk_run);
        end else begin
          check("alu_clk_en_len", clk_run, exp_clk_len.pop_front());
        end
        clk_run = 0;
      end
      if (hold_pending) begin
        check("tx_hold_valid", tx_valid, 1'b1);
        check("tx_hold_data", tx_data, held_data);
      end
      if (tx_valid && tx_ready) begin
        hold_pending = 1'b0;
        if (exp_tx.size() == 0) begin
          total++; bad++;
          $display("FAIL tx_unexpected actual=%0h required=none", tx_data);
        end else begin
          check("tx_byte", tx_data, exp_tx.pop_front());
        end
      end else if (tx_valid) begin
        hold_pending = 1'b1;
        held_data = tx_data;
      end else begin
        hold_pending = 1'b0;
      end
      if (err_timeout) got_timeouts++;
      if (err_overrun) got_overruns++;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk);
    #1;
    rx_data = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_data = 8'($urandom);
  endtask

  task automatic wait_idle(input string name);
    int i;
    for (i = 0; i < 500 && busy; i++) @(negedge clk);
    check({name, "_idle_bound"}, busy, 1'b0);
    @(negedge clk);
    check({name, "_tx_valid_idle"}, tx_valid, 1'b0);
    check({name, "_tx_drained"}, exp_tx.size(), 0);
    check({name, "_ops_drained"}, exp_ops.size() + exp_clk_len.size(), 0);
  endtask

  task automatic run_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] f,
                           input int lat, input bit ovr, input bit junk);
    logic [15:0] r;
    logic [7:0]  jb;
    int i;
    if (f[7:4] == 4'h0 && f[3:0] != 4'hF) begin
      r = alu_ref(a, b, f[3:0]);
      exp_ops.push_back({a, b, f[3:0]});
      if (lat > 0) begin
        exp_clk_len.push_back(lat + 1);
        exp_tx.push_back(r[7:0]);
        exp_tx.push_back(r[15:8]);
      end else begin
        exp_clk_len.push_back(TIMEOUT + 1);
        exp_tx.push_back(8'hEE);
        exp_timeouts++;
      end
    end else begin
      exp_tx.push_back(8'hEE);
    end
    alu_lat = lat;
    if (ovr) stall = 1'b1;
    if (junk) begin
      jb = 8'($urandom);
      if (jb == 8'hCC) jb = 8'h3C;
      send_byte(jb);
    end
    send_byte(8'hCC);
    send_byte(a);
    send_byte(b);
    send_byte(f);
    if (ovr) begin
      for (i = 0; i < 100 && !tx_valid; i++) @(negedge clk);
      check("ovr_tx_valid_bound", tx_valid, 1'b1);
      send_byte(8'h55);
      exp_overruns++;
      repeat (5) @(posedge clk);
      stall = 1'b0;
    end
    wait_idle("frame");
  endtask

  initial begin : watchdog
    #1ms;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [7:0] a, b, f;
    int lat, sel;
    rst_n = 1'b0;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_outputs", {alu_a, alu_b, alu_fun, alu_en, alu_clk_en, tx_data, tx_valid,
                            busy, err_overrun, err_timeout}, 64'h0);
    #2 rst_n = 1'b1;

    run_frame(8'h05, 8'h03, 8'h00, 1, 1'b0, 1'b0);
    run_frame(8'hFF, 8'hFF, 8'h02, 1, 1'b0, 1'b1);
    run_frame(8'h01, 8'h02, 8'h0F, 1, 1'b0, 1'b0);
    run_frame(8'h01, 8'h02, 8'h13, 1, 1'b0, 1'b0);
    run_frame(8'h01, 8'h02, 8'h03, 0, 1'b0, 1'b0);
    run_frame(8'h10, 8'h20, 8'h01, TIMEOUT, 1'b0, 1'b0);
    run_frame(8'h05, 8'h03, 8'h00, 1, 1'b1, 1'b0);
    run_frame(8'h07, 8'h09, 8'h05, 0, 1'b1, 1'b0);

    // Reset while waiting for a result: the aborted frame must send nothing.
    alu_lat = 0;
    exp_ops.push_back({8'h01, 8'h02, 4'h3});
    send_byte(8'hCC);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    check("midop_reset_outputs", {alu_a, alu_b, alu_fun, alu_en, alu_clk_en, tx_data,
                                  tx_valid, busy, err_overrun, err_timeout}, 64'h0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    run_frame(8'h02, 8'h02, 8'h04, 1, 1'b0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      sel = $urandom_range(0, 9);
      if (sel == 0) f = 8'h0F;
      else if (sel == 1) f = {4'($urandom_range(1, 15)), 4'($urandom)};
      else f = {4'h0, 4'($urandom_range(0, 14))};
      case ($urandom_range(0, 6))
        0: lat = 0;
        1: lat = TIMEOUT;
        2: lat = $urandom_range(2, TIMEOUT - 1);
        default: lat = $urandom_range(1, 3);
      endcase
      run_frame(a, b, f, lat, ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0));
    end

    check("timeout_pulses", got_timeouts, exp_timeouts);
    check("overrun_pulses", got_overruns, exp_overruns);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
